// File: rtl/cv32e40p_clock_gate_ctrl.sv
// Multi-channel automatic clock-gating controller.
// Each channel owns a small FSM that drops its clock-gate enable after a
// programmable run of idle cycles, and restores it through a wake
// request / acknowledge handshake. Runs in the always-on clock domain.
module cv32e40p_clock_gate_ctrl #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned WAKE_CYCLES = 2,
  localparam int unsigned CNT_MAX    = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES,
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              test_en_i,
  input  logic [NUM_CH-1:0] gate_allow_i,
  input  logic [NUM_CH-1:0] busy_i,
  input  logic [NUM_CH-1:0] wake_req_i,
  output logic [NUM_CH-1:0] gate_en_o,
  output logic [NUM_CH-1:0] gated_o,
  output logic [NUM_CH-1:0] wake_ack_o
);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_IDLE_CNT,
    ST_GATED,
    ST_WAKEUP
  } state_e;

  // With no idle budget the channel gates on the first idle cycle and the
  // IDLE_CNT state is never entered.
  localparam bit               IDLE_BYPASS = (IDLE_CYCLES == 0);
  localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] WAKE_LAST   = CNT_W'(WAKE_CYCLES - 1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             gated_q;
    logic             ack_q;
    logic             allow;
    logic             activity;

    assign allow    = gate_allow_i[c] & ~test_en_i;
    assign activity = busy_i[c] | wake_req_i[c];

    // Per-channel gating FSM with registered status and ack outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= ST_ACTIVE;
        cnt_q   <= '0;
        gated_q <= 1'b0;
        ack_q   <= 1'b0;
      end else begin
        ack_q <= 1'b0;
        case (state_q)
          ST_ACTIVE: begin
            if (!activity && allow) begin
              cnt_q <= '0;
              if (IDLE_BYPASS) begin
                state_q <= ST_GATED;
                gated_q <= 1'b1;
              end else begin
                state_q <= ST_IDLE_CNT;
              end
            end
          end
          ST_IDLE_CNT: begin
            // Activity has priority over counter expiry on the same edge.
            if (activity || !allow) begin
              state_q <= ST_ACTIVE;
              cnt_q   <= '0;
            end else if (cnt_q == IDLE_LAST) begin
              state_q <= ST_GATED;
              gated_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_GATED: begin
            if (activity || !allow) begin
              state_q <= ST_WAKEUP;
              cnt_q   <= '0;
              gated_q <= 1'b0;
            end
          end
          ST_WAKEUP: begin
            // Inputs are deliberately ignored until the wake sequence ends.
            if (cnt_q == WAKE_LAST) begin
              state_q <= ST_ACTIVE;
              cnt_q   <= '0;
              ack_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
            gated_q <= 1'b0;
          end
        endcase
      end
    end

    // The state term only changes just after the rising edge, while the
    // gate cell latch is opaque, so the enable it captures is glitch-free.
    assign gate_en_o[c]  = ~gated_q | test_en_i;
    assign gated_o[c]    = gated_q;
    assign wake_ack_o[c] = ack_q;
  end

endmodule

// File: tb/tb_cv32e40p_clock_gate_ctrl.sv
// Self-checking bench for cv32e40p_clock_gate_ctrl.
// Two instances (IDLE_CYCLES=4 and IDLE_CYCLES=0) share all inputs and are
// compared every cycle against a behavioural model, plus directed checks.
module tb_cv32e40p_clock_gate_ctrl;

  localparam int NCH = 4;
  localparam int WAKE = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic test_en;
  logic [NCH-1:0] allow, busy, wreq;
  logic [NCH-1:0] gate_en_a, gated_a, ack_a;
  logic [NCH-1:0] gate_en_b, gated_b, ack_b;

  int n_asserts = 0;
  int n_fail    = 0;

  // Behavioural model: mode 0 = clock running, 1 = gated, 2 = waking up.
  int idle_lim[2] = '{4, 0};
  int mode[2][NCH];
  int idle_run[2][NCH];
  int wake_left[2][NCH];
  bit ack_m[2][NCH];

  always #5 clk = ~clk;

  cv32e40p_clock_gate_ctrl #(
    .NUM_CH(NCH), .IDLE_CYCLES(4), .WAKE_CYCLES(WAKE)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
    .gate_allow_i(allow), .busy_i(busy), .wake_req_i(wreq),
    .gate_en_o(gate_en_a), .gated_o(gated_a), .wake_ack_o(ack_a)
  );

  cv32e40p_clock_gate_ctrl #(
    .NUM_CH(NCH), .IDLE_CYCLES(0), .WAKE_CYCLES(WAKE)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
    .gate_allow_i(allow), .busy_i(busy), .wake_req_i(wreq),
    .gate_en_o(gate_en_b), .gated_o(gated_b), .wake_ack_o(ack_b)
  );

  task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        mode[d][c] = 0; idle_run[d][c] = 0; wake_left[d][c] = 0; ack_m[d][c] = 1'b0;
      end
  endtask

  // One rising edge: a channel gates once it has seen idle_lim+1 consecutive
  // idle-and-allowed samples, and acks after WAKE edges spent waking.
  task automatic model_edge();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        bit ok_gate = allow[c] & ~test_en;
        bit act     = busy[c] | wreq[c];
        ack_m[d][c] = 1'b0;
        if (mode[d][c] == 0) begin
          if (!act && ok_gate) begin
            idle_run[d][c]++;
            if (idle_run[d][c] > idle_lim[d]) begin
              mode[d][c] = 1; idle_run[d][c] = 0;
            end
          end else idle_run[d][c] = 0;
        end else if (mode[d][c] == 1) begin
          if (act || !ok_gate) begin
            mode[d][c] = 2; wake_left[d][c] = WAKE;
          end
        end else begin
          wake_left[d][c]--;
          if (wake_left[d][c] == 0) begin
            mode[d][c] = 0; ack_m[d][c] = 1'b1;
          end
        end
      end
  endtask

  task automatic check_model(input string tag);
    for (int d = 0; d < 2; d++) begin
      logic [NCH-1:0] eg, eq, ea;
      for (int c = 0; c < NCH; c++) begin
        eq[c] = (mode[d][c] == 1);
        ea[c] = ack_m[d][c];
      end
      eg = ~eq | {NCH{test_en}};
      if (d == 0) begin
        chk({tag, "_a_en"}, gate_en_a, eg);
        chk({tag, "_a_gated"}, gated_a, eq);
        chk({tag, "_a_ack"}, ack_a, ea);
      end else begin
        chk({tag, "_b_en"}, gate_en_b, eg);
        chk({tag, "_b_gated"}, gated_b, eq);
        chk({tag, "_b_ack"}, ack_b, ea);
      end
    end
  endtask

  // Inputs only change on the falling edge, so they are stable at posedge.
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; test_en = 1'b0; allow = '1; busy = '1; wreq = '0;
    model_reset();
    #3;
    chk("rst_en", gate_en_a, 4'b1111);
    chk("rst_gated", gated_a, 4'b0000);
    chk("rst_ack", ack_a, 4'b0000);
    chk("rst_b_en", gate_en_b, 4'b1111);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step("settle"); step("settle");

    // 1: busy[0] falls; enable holds for IDLE+... then drops on 5th edge.
    busy[0] = 1'b0;
    for (int i = 0; i < 4; i++) step("t1");
    chk("t1_hold_en", gate_en_a, 4'b1111);
    step("t1");
    chk("t1_gate_en", gate_en_a, 4'b1110);
    chk("t1_gated", gated_a, 4'b0001);

    // 2: one-cycle wake request on channel 0.
    wreq[0] = 1'b1;
    step("t2");
    wreq[0] = 1'b0; busy = '1;
    chk("t2_en", gate_en_a, 4'b1111);
    chk("t2_gated", gated_a, 4'b0000);
    chk("t2_ack0", ack_a, 4'b0000);
    step("t2");
    chk("t2_ack1", ack_a, 4'b0000);
    step("t2");
    chk("t2_ack2", ack_a, 4'b0001);
    step("t2");
    chk("t2_ack3", ack_a, 4'b0000);

    // 3: busy[1] returns after 3 idle cycles, then exactly on expiry.
    busy[1] = 1'b0;
    for (int i = 0; i < 3; i++) step("t3a");
    busy[1] = 1'b1;
    step("t3a");
    chk("t3a_en", gate_en_a, 4'b1111);
    busy[1] = 1'b0;
    for (int i = 0; i < 4; i++) step("t3b");
    busy[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("t3b");
      chk("t3b_en", gate_en_a, 4'b1111);
      chk("t3b_ack", ack_a, 4'b0000);
    end

    // 4: gate everything, then test mode forces enables and wakes all.
    busy = '0;
    for (int i = 0; i < 6; i++) step("t4");
    chk("t4_all_gated", gated_a, 4'b1111);
    test_en = 1'b1;
    #1;
    chk("t4_force_en", gate_en_a, 4'b1111);
    chk("t4_force_en_b", gate_en_b, 4'b1111);
    chk("t4_gated_kept", gated_a, 4'b1111);
    step("t4"); step("t4");
    chk("t4_ack_early", ack_a, 4'b0000);
    step("t4");
    chk("t4_ack", ack_a, 4'b1111);
    for (int i = 0; i < 3; i++) step("t4_hold");
    chk("t4_hold_gated", gated_a, 4'b0000);
    test_en = 1'b0; busy = '1;
    step("t4_exit");

    // 5: async reset while channel 2 is waking.
    busy = 4'b1011;
    for (int i = 0; i < 6; i++) step("t5");
    chk("t5_gated", gated_a, 4'b0100);
    wreq[2] = 1'b1;
    step("t5");
    wreq[2] = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_en", gate_en_a, 4'b1111);
    chk("t5_rst_gated", gated_a, 4'b0000);
    chk("t5_rst_ack", ack_a, 4'b0000);
    busy = '1;
    step("t5_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("t5_post");
      chk("t5_no_ack", ack_a, 4'b0000);
    end

    // 6: IDLE_CYCLES=0 instance, gating permission on channel 3.
    busy[3] = 1'b0; allow[3] = 1'b0;
    for (int i = 0; i < 3; i++) step("t6");
    chk("t6_blocked", {3'b000, gated_b[3]}, 4'b0000);
    allow[3] = 1'b1;
    step("t6");
    chk("t6_gated", {3'b000, gated_b[3]}, 4'b0001);

    // Randomized traffic against the model.
    busy = '1; allow = '1; wreq = '0;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 7) == 0) busy[c] = ~busy[c];
        if ($urandom_range(0, 15) == 0) allow[c] = ~allow[c];
        wreq[c] = ($urandom_range(0, 15) == 0);
      end
      test_en = ($urandom_range(0, 40) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_clock_gate_ctrl.md
Name: cv32e40p_clock_gate_ctrl

Overview:
- Multi-channel automatic clock-gating controller.
- Generates one registered, glitch-free enable per channel. Each enable drives the en_i of a per-channel cv32e40p_clock_gate cell.
- A channel is gated after it has been idle for a programmable number of cycles. It is ungated again through a wake request/acknowledge handshake.
- Sits beside the core/peripheral clock tree in the always-on clock domain.

Parameters:
NUM_CH, 4, number of independently gated channels (>=1).
IDLE_CYCLES, 8, consecutive idle cycles before gating (>=0; 0 = gate on the first idle cycle).
WAKE_CYCLES, 2, cycles the enable is held high before wake_ack_o is asserted (>=1).
CNT_W, $clog2(max(IDLE_CYCLES,WAKE_CYCLES)+1), idle/wake counter width (derived, do not override).

Ports:
clk_i  input  1  free-running clock
rst_ni  input  1  asynchronous active-low reset
test_en_i  input  1  scan/test mode; forces all enables high
gate_allow_i  input  NUM_CH  per-channel permission to gate
busy_i  input  NUM_CH  channel activity; 1 = channel needs its clock
wake_req_i  input  NUM_CH  request to ungate the channel
gate_en_o  output  NUM_CH  enable to the clock gate cell
gated_o  output  NUM_CH  status: 1 while the channel is gated
wake_ack_o  output  NUM_CH  one-cycle pulse: channel clock is stable again

Behaviour:
- One independent FSM and CNT_W counter per channel. All state is registered on the rising edge of clk_i.
- Async reset (rst_ni=0): state=ACTIVE, cnt=0, gate_en_o=all 1, gated_o=0, wake_ack_o=0.
- "allow" = gate_allow_i[c] & ~test_en_i.
- "activity" = busy_i[c] | wake_req_i[c].
- ACTIVE:
  - if ~activity & allow: go to IDLE_CNT with cnt=0, or go straight to GATED when IDLE_CYCLES=0.
  - otherwise stay in ACTIVE.
- IDLE_CNT:
  - if activity | ~allow: go to ACTIVE, cnt=0.
  - else if cnt==IDLE_CYCLES-1: go to GATED.
  - else cnt++.
  - Net effect: busy_i falls at edge k, and gate_en_o is first low after edge k+IDLE_CYCLES+1.
- GATED:
  - if activity | ~allow: go to WAKEUP with cnt=0.
  - otherwise stay in GATED.
- WAKEUP:
  - if cnt==WAKE_CYCLES-1: go to ACTIVE.
  - else cnt++.
  - Inputs are ignored while in WAKEUP: no abort and no re-gating. wake_req_i is level-sensitive and harmless here.
- wake_ack_o[c]: registered, high exactly for the first cycle in ACTIVE after WAKEUP. It is never asserted on other transitions.
- gate_en_o[c] = (state!=GATED) | test_en_i. The state term is registered, so it changes only just after the rising edge while clk_i is high. The latch in the gate cell is transparent only while clk_i is low, so it sees a stable enable and no glitch reaches clk_o.
- gated_o[c] = (state==GATED). It is not affected by test_en_i.
- Simultaneous events:
  - busy_i rising on the same edge the counter expires: activity wins, and the channel returns to ACTIVE without gating.
  - Both busy_i and wake_req_i high in GATED: one WAKEUP sequence and one ack pulse.
- test_en_i=1:
  - All enables are high combinationally.
  - IDLE_CNT channels return to ACTIVE.
  - GATED channels enter WAKEUP and complete it normally, so an ack pulse follows.
- Reset mid-operation: immediate return to reset values from any state. No ack pulse is generated.
- Channels share no state. Per-channel behaviour is identical for every NUM_CH.

Test Plan:
1. IDLE_CYCLES=4, WAKE_CYCLES=2; after reset, drop busy_i[0] at edge 10 -> gate_en_o[0] stays 1 through edge 14, is 0 and gated_o[0]=1 from edge 15; other channels with busy=1 stay enabled.
2. Channel 0 gated; pulse wake_req_i[0] one cycle at edge 20 -> gate_en_o[0]=1 from edge 21, wake_ack_o[0]=1 only in the cycle after edge 23, gated_o[0]=0.
3. busy_i[1] falls, then rises again after 3 idle cycles (IDLE_CYCLES=4); also raise busy on the exact expiry edge -> gate_en_o[1] never drops, no wake_ack_o[1].
4. All channels gated; assert test_en_i -> gate_en_o=4'b1111 in the same cycle; after WAKE_CYCLES, wake_ack_o=4'b1111 for one cycle, and the channels remain ACTIVE while test_en_i=1.
5. Channel 2 in WAKEUP (cnt=0); assert rst_ni=0 asynchronously mid-cycle -> gate_en_o=1111, gated_o=0, and wake_ack_o=0 immediately; no ack after release.
6. IDLE_CYCLES=0 build; gate_allow_i[3]=0 with busy_i[3]=0 -> never gates; set gate_allow_i[3]=1 -> gated_o[3]=1 after the next edge.
